// File: rtl/stream_demux.sv
// stream_demux: steers each accepted word into one of N_OUT single-entry output channels.
// Optional macro STREAM_DEMUX_SELERR_EN adds a sticky flag for out-of-range selects.
module stream_demux #(
   parameter int WIDTH = 32,
   parameter int N_OUT = 4,
   localparam int SEL_W = (N_OUT > 2) ? $clog2(N_OUT) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [SEL_W-1:0]         in_sel,
   output logic [N_OUT-1:0]         out_valid,
   input  logic [N_OUT-1:0]         out_ready,
   output logic [N_OUT*WIDTH-1:0]   out_data,
   output logic                     sel_err,
   output logic [N_OUT-1:0]         state_dbg
);

   // Handshake: a word moves across an interface exactly at a rising edge where
   // valid and ready are both high; valid never waits on ready, and ready for the
   // input depends only on the channel named by in_sel.

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chan_state_t;

   chan_state_t      state_q [N_OUT];
   chan_state_t      state_d [N_OUT];
   logic [WIDTH-1:0] data_q  [N_OUT];
   logic [WIDTH-1:0] data_d  [N_OUT];

   logic [N_OUT-1:0] sel_hit;
   logic [N_OUT-1:0] full;
   logic [N_OUT-1:0] drain;
   logic [N_OUT-1:0] load;
   logic             in_range;
   logic             accept;

   // One-hot decode by comparison, so an out-of-range select simply hits nothing.
   always_comb begin
      sel_hit = '0;
      for (int k = 0; k < N_OUT; k++) begin
         sel_hit[k] = (in_sel == SEL_W'(k));
      end
   end

   always_comb begin
      full = '0;
      for (int k = 0; k < N_OUT; k++) begin
         full[k] = (state_q[k] == FULL);
      end
   end

   assign in_range = |sel_hit;
   assign in_ready = !in_range | (|(sel_hit & (~full | out_ready)));
   assign accept   = in_valid & in_ready;
   assign drain    = full & out_ready;
   assign load     = sel_hit & {N_OUT{accept}};

   // A load into a FULL channel is only possible while it drains, so it stays FULL.
   always_comb begin
      for (int k = 0; k < N_OUT; k++) begin
         state_d[k] = state_q[k];
         data_d[k]  = data_q[k];
         case (state_q[k])
            EMPTY: begin
               if (load[k]) begin
                  state_d[k] = FULL;
                  data_d[k]  = in_data;
               end
            end
            FULL: begin
               if (load[k]) begin
                  data_d[k] = in_data;
               end else if (drain[k]) begin
                  state_d[k] = EMPTY;
               end
            end
            default: begin
               state_d[k] = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_OUT; k++) begin
            state_q[k] <= EMPTY;
            data_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < N_OUT; k++) begin
            state_q[k] <= state_d[k];
            data_q[k]  <= data_d[k];
         end
      end
   end

   // Drained registers keep stale data, so empty slices are masked to zero.
   always_comb begin
      out_data  = '0;
      out_valid = full;
      state_dbg = '0;
      for (int k = 0; k < N_OUT; k++) begin
         state_dbg[k] = state_q[k];
         if (full[k]) begin
            out_data[k*WIDTH +: WIDTH] = data_q[k];
         end
      end
   end

`ifdef STREAM_DEMUX_SELERR_EN
   logic sel_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err_q <= 1'b0;
      end else if (in_valid && !in_range) begin
         sel_err_q <= 1'b1;
      end
   end

   assign sel_err = sel_err_q;
`else
   assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed vector table, hand-written corner sequences and a
// randomized run against a per-channel queue model for stream_demux.
module tb_stream_demux;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int W3 = 8;
   localparam int N3 = 3;

`ifdef STREAM_DEMUX_SELERR_EN
   localparam logic EXP_SELERR = 1'b1;
`else
   localparam logic EXP_SELERR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic [1:0]       in_sel;
   logic [N-1:0]     out_valid;
   logic [N-1:0]     out_ready;
   logic [N*W-1:0]   out_data;
   logic             sel_err;
   logic [N-1:0]     state_dbg;

   logic             d3_in_valid;
   logic             d3_in_ready;
   logic [W3-1:0]    d3_in_data;
   logic [1:0]       d3_in_sel;
   logic [N3-1:0]    d3_out_valid;
   logic [N3-1:0]    d3_out_ready;
   logic [N3*W3-1:0] d3_out_data;
   logic             d3_sel_err;
   logic [N3-1:0]    d3_state_dbg;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] chan_q [N][$];

   stream_demux #(.WIDTH(W), .N_OUT(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sel_err   (sel_err),
      .state_dbg (state_dbg)
   );

   stream_demux #(.WIDTH(W3), .N_OUT(N3)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (d3_in_valid),
      .in_ready  (d3_in_ready),
      .in_data   (d3_in_data),
      .in_sel    (d3_in_sel),
      .out_valid (d3_out_valid),
      .out_ready (d3_out_ready),
      .out_data  (d3_out_data),
      .sel_err   (d3_sel_err),
      .state_dbg (d3_state_dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic         valid;
      logic [1:0]   sel;
      logic [W-1:0] data;
      logic [N-1:0] rdy;
      logic         exp_ready;
      logic [N-1:0] exp_valid;
      logic [N*W-1:0] exp_data;
   } vec_t;

   vec_t vec [12];

   function automatic logic [N*W-1:0] pack4(input logic [W-1:0] s3, input logic [W-1:0] s2,
                                             input logic [W-1:0] s1, input logic [W-1:0] s0);
      return {s3, s2, s1, s0};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [N-1:0] r);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
   endtask

   task automatic d3_drive(input logic v, input logic [1:0] s, input logic [W3-1:0] d);
      d3_in_valid  = v;
      d3_in_sel    = s;
      d3_in_data   = d;
      d3_out_ready = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N-1:0]   exp_ov;
      logic [N*W-1:0] exp_od;
      logic           exp_rdy;
      logic [W-1:0]   w;

      vec[0]  = '{1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b1, 4'b0100, pack4(0, 32'hDEADBEEF, 0, 0)};
      vec[1]  = '{1'b1, 2'd1, 32'h0000AAAA, 4'b0000, 1'b1, 4'b0110, pack4(0, 32'hDEADBEEF, 32'hAAAA, 0)};
      vec[2]  = '{1'b1, 2'd1, 32'h00005555, 4'b0000, 1'b0, 4'b0110, pack4(0, 32'hDEADBEEF, 32'hAAAA, 0)};
      vec[3]  = '{1'b1, 2'd1, 32'h00000011, 4'b0010, 1'b1, 4'b0110, pack4(0, 32'hDEADBEEF, 32'h11, 0)};
      vec[4]  = '{1'b0, 2'd0, 32'h00000000, 4'b0110, 1'b1, 4'b0000, pack4(0, 0, 0, 0)};
      vec[5]  = '{1'b1, 2'd0, 32'h00000033, 4'b0000, 1'b1, 4'b0001, pack4(0, 0, 0, 32'h33)};
      vec[6]  = '{1'b1, 2'd3, 32'h00000022, 4'b0000, 1'b1, 4'b1001, pack4(32'h22, 0, 0, 32'h33)};
      vec[7]  = '{1'b1, 2'd0, 32'h00000044, 4'b0000, 1'b0, 4'b1001, pack4(32'h22, 0, 0, 32'h33)};
      vec[8]  = '{1'b0, 2'd3, 32'h0000FFFF, 4'b1000, 1'b1, 4'b0001, pack4(0, 0, 0, 32'h33)};
      vec[9]  = '{1'b1, 2'd2, 32'h00000066, 4'b0001, 1'b1, 4'b0100, pack4(0, 32'h66, 0, 0)};
      vec[10] = '{1'b0, 2'd2, 32'h00000099, 4'b0000, 1'b0, 4'b0100, pack4(0, 32'h66, 0, 0)};
      vec[11] = '{1'b0, 2'd2, 32'h00000099, 4'b0100, 1'b1, 4'b0000, pack4(0, 0, 0, 0)};

      // reset
      drive(1'b0, 2'd0, '0, '0);
      d3_drive(1'b0, 2'd0, '0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset sel_err", sel_err, 0);
      check("reset in_ready", in_ready, 1);
      check("reset d3 out_valid", d3_out_valid, 0);
      rst_n = 1'b1;

      // directed table: row 0 is the first edge after reset release
      for (int i = 0; i < 12; i++) begin
         drive(vec[i].valid, vec[i].sel, vec[i].data, vec[i].rdy);
         @(negedge clk);
         check($sformatf("vec%0d in_ready", i), in_ready, vec[i].exp_ready);
         step();
         check($sformatf("vec%0d out_valid", i), out_valid, vec[i].exp_valid);
         check($sformatf("vec%0d out_data", i), out_data, vec[i].exp_data);
         check($sformatf("vec%0d state_dbg", i), state_dbg, vec[i].exp_valid);
      end

      // streaming: 8 words into ch0 on consecutive cycles, order preserved
      for (int i = 0; i < 8; i++) begin
         w = $urandom();
         drive(1'b1, 2'd0, w, 4'b0001);
         @(negedge clk);
         check($sformatf("stream%0d in_ready", i), in_ready, 1);
         if (in_ready) exp_q.push_back(w);
         step();
         check($sformatf("stream%0d out_valid", i), out_valid, 4'b0001);
         if (exp_q.size() != 0) begin
            check($sformatf("stream%0d data", i), out_data[W-1:0], exp_q.pop_front());
         end
      end
      drive(1'b0, 2'd0, '0, 4'b0001);
      step();
      check("stream drained", out_valid, 0);

      // reset mid-operation with all channels full
      for (int k = 0; k < N; k++) begin
         drive(1'b1, 2'(k), 32'h100 + k, 4'b0000);
         step();
      end
      check("fill all out_valid", out_valid, 4'b1111);
      drive(1'b1, 2'd1, 32'hBAD, 4'b0000);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst out_valid", out_valid, 0);
      check("async rst out_data", out_data, 0);
      check("async rst in_ready", in_ready, 1);
      check("async rst sel_err", sel_err, 0);
      step();
      rst_n = 1'b1;
      drive(1'b0, 2'd0, '0, 4'b0000);
      step();
      check("after rst no replay", out_valid, 0);

      // randomized run against per-channel capacity-one queues
      for (int k = 0; k < N; k++) chan_q[k].delete();
      for (int c = 0; c < 300; c++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(),
               4'($urandom_range(0, 15)));
         @(negedge clk);
         exp_ov = '0;
         exp_od = '0;
         for (int k = 0; k < N; k++) begin
            if (chan_q[k].size() != 0) begin
               exp_ov[k] = 1'b1;
               exp_od[k*W +: W] = chan_q[k][0];
            end
         end
         exp_rdy = (chan_q[in_sel].size() == 0) || out_ready[in_sel];
         check($sformatf("rand%0d out_valid", c), out_valid, exp_ov);
         check($sformatf("rand%0d out_data", c), out_data, exp_od);
         check($sformatf("rand%0d in_ready", c), in_ready, exp_rdy);
         for (int k = 0; k < N; k++) begin
            if (chan_q[k].size() != 0 && out_ready[k]) void'(chan_q[k].pop_front());
         end
         if (in_valid && exp_rdy) chan_q[in_sel].push_back(in_data);
         step();
      end
      drive(1'b0, 2'd0, '0, 4'b0000);

      // out-of-range select on the three-channel instance
      d3_drive(1'b1, 2'd1, 8'h5A);
      step();
      check("d3 fill out_valid", d3_out_valid, 3'b010);
      check("d3 sel_err before", d3_sel_err, 0);
      d3_drive(1'b1, 2'd3, 8'hC3);
      @(negedge clk);
      check("d3 oor in_ready", d3_in_ready, 1);
      step();
      check("d3 oor out_valid", d3_out_valid, 3'b010);
      check("d3 oor out_data", d3_out_data, 24'h005A00);
      check("d3 oor sel_err", d3_sel_err, EXP_SELERR);
      d3_drive(1'b0, 2'd0, '0);
      step();
      check("d3 sel_err sticky", d3_sel_err, EXP_SELERR);
      rst_n = 1'b0;
      #1;
      check("d3 sel_err reset", d3_sel_err, 0);
      check("d3 reset out_valid", d3_out_valid, 0);
      step();
      rst_n = 1'b1;

      // final report
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, legal 1..64.
REQ-002 SHALL have parameter N_OUT, default 4: output channel count, legal 2..16.
REQ-003 SHALL derive local SEL_W = ceil(log2(N_OUT)), minimum 1.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1: upstream word present.
REQ-007 SHALL have port in_ready  output  1: upstream word accepted this cycle when in_valid is also high.
REQ-008 SHALL have port in_data  input  WIDTH: payload.
REQ-009 SHALL have port in_sel  input  SEL_W: destination channel index, qualified by in_valid.
REQ-010 SHALL have port out_valid  output  N_OUT: per-channel word present.
REQ-011 SHALL have port out_ready  input  N_OUT: per-channel consumer accepts.
REQ-012 SHALL have port out_data  output  N_OUT*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-013 SHALL have port sel_err  output  1: sticky out-of-range-select flag.

Function
REQ-014 SHALL give each channel a one-entry holding register plus a full flag, with two states: EMPTY (full=0) and FULL (full=1).
REQ-015 SHALL drive out_valid[k] = full[k].
REQ-016 SHALL drive out_data slice k = holding register k when full[k]=1, and all-zero when full[k]=0.
REQ-017 SHALL compute in_ready combinationally: for in_sel < N_OUT, in_ready = !full[in_sel] | out_ready[in_sel].
REQ-018 SHALL count an accept when in_valid & in_ready are both high at a rising edge.
REQ-019 SHALL count a drain of channel k when full[k] & out_ready[k] are both high at a rising edge.
REQ-020 SHALL load in_data into channel in_sel on accept and set its full flag; the word is visible on out_valid/out_data the next cycle (latency 1).
REQ-021 SHALL, when accept and drain hit the same channel in the same cycle, load the new word and keep full=1, giving one word per cycle per channel.
REQ-022 SHALL, on drain without a same-channel accept, clear full[k] (FULL -> EMPTY).
REQ-023 SHALL let non-selected channels drain independently in the same cycle as an accept.
REQ-024 SHALL hold a full channel's data stable while out_ready[k]=0, whatever in_data or in_sel do.
REQ-025 SHALL have in_ready depend only on the selected channel: a stalled channel must not block words bound for other channels.
REQ-026 SHALL keep holding registers unchanged when in_valid=0.
REQ-027 SHALL not depend on in_ready for its own in_valid/in_sel/in_data behaviour: no combinational path from in_ready back to the inputs.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force: every full flag to 0, all holding registers to 0, sel_err to 0.
REQ-029 SHALL therefore, during reset, present out_valid=0, all out_data=0 and sel_err=0, with in_ready following REQ-017 on the cleared flags.
REQ-030 SHALL discard any word held or in flight when reset is asserted mid-operation; nothing is replayed after reset.
REQ-031 SHALL allow the first accept at the first rising edge after rst_n deasserts.

Configuration
REQ-032 SHALL support the preprocessor macro STREAM_DEMUX_SELERR_EN.
REQ-033 With STREAM_DEMUX_SELERR_EN defined: a word with in_sel >= N_OUT SHALL see in_ready=1, SHALL be dropped, and SHALL set sel_err=1 at that edge; sel_err stays set until reset.
REQ-034 Without STREAM_DEMUX_SELERR_EN: a word with in_sel >= N_OUT SHALL see in_ready=1 and SHALL be silently dropped, and sel_err SHALL be tied to 0.
REQ-035 SHALL leave behaviour for in-range selects identical in both builds.

Verification
REQ-036 SHALL cover reset then single word: in_data=0xDEADBEEF, in_sel=2 accepted -> next cycle out_valid=4'b0100, slice 2 = 0xDEADBEEF, other slices 0.
REQ-037 SHALL cover back-pressure: ch1 full, out_ready[1]=0, in_sel=1 -> in_ready=0 and slice 1 unchanged; then out_ready[1]=1 with a new word 0x11 -> same-edge replace, slice 1 = 0x11, out_valid[1] stays 1.
REQ-038 SHALL cover non-blocking: ch0 full and stalled, word 0x22 with in_sel=3 -> in_ready=1, next cycle out_valid=4'b1001.
REQ-039 SHALL cover streaming: 8 words to ch0 with out_ready[0]=1 held -> 8 accepts in 8 consecutive cycles, order preserved.
REQ-040 SHALL cover reset mid-operation: rst_n pulled low asynchronously with all channels full -> out_valid=0 and out_data=0 immediately, before the next clock edge.
REQ-041 SHALL cover the out-of-range select: N_OUT=3, in_sel=3 -> word dropped and out_valid unchanged; sel_err=1 with STREAM_DEMUX_SELERR_EN, 0 without it.
